fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- Next-generation instruction fetch stage: PC register, stall/backpressure, branch/jump redirect with flush, end-of-program halt, fetch counter.
- Sits between combinational instruction memory (async read) and decode.
- Drives `imem_addr`, registers the returned word with its PC into a one-deep fetch/decode register.

Parameters:
- XLEN, 32, PC and address width.
- RESET_PC, 0, PC value loaded on reset.
- END_PC, 32'h1C, address of last instruction; fetch halts after issuing it.
- HALT_STICKY, 0, 1 = halt cleared only by reset; 0 = a redirect also clears halt.
- CNT_W, 16, width of fetch_count.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  decode backpressure; freezes PC and output register.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  XLEN  redirect target.
- imem_addr  out  XLEN  instruction memory address (= pc, combinational).
- imem_rdata  in  32  instruction word at imem_addr, same cycle.
- out_valid  out  1  out_pc/out_instr hold a valid instruction.
- out_pc  out  XLEN  PC of the instruction in the output register.
- out_instr  out  32  instruction word.
- halted  out  1  END_PC instruction issued; no further fetches.
- misalign_err  out  1  one-cycle pulse: redirect_pc[1:0] != 0.
- fetch_count  out  CNT_W  instructions issued since reset, saturating.

Behaviour:
- Reset (async, immediate):
  - pc = RESET_PC.
  - out_valid = 0, out_pc = 0, out_instr = 0.
  - halted = 0, misalign_err = 0, fetch_count = 0.
- Per-edge priority: redirect > halted > stall > advance.
- Redirect (redirect_valid = 1, regardless of stall/halted):
  - pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - out_valid <= 0 (wrong-path flush); out_pc/out_instr hold.
  - misalign_err <= (redirect_pc[1:0] != 0); otherwise misalign_err <= 0 every cycle.
  - If HALT_STICKY = 0: halted <= 0. If HALT_STICKY = 1: halted unchanged and pc still loads, but no fetch resumes until reset.
  - fetch_count unchanged.
- Halted (halted = 1, no redirect):
  - pc holds; out_valid <= 0 once decode accepts (stall = 0); nothing issued.
- Stall (stall = 1, no redirect): pc, out_* and fetch_count hold.
- Advance (stall = 0, not halted, no redirect):
  - out_pc <= pc; out_instr <= imem_rdata; out_valid <= 1.
  - fetch_count <= fetch_count + 1, saturating at all-ones.
  - If pc == END_PC: halted <= 1, pc holds. Else pc <= pc + 4, wrapping mod 2^XLEN.
- Latency: instruction at pc appears on out_* one edge after an advance cycle.
- Throughput: one instruction per unstalled cycle.
- After halt with no redirect, pc == END_PC permanently.
- Redirect to END_PC: the END_PC instruction is fetched once, then halted = 1.
- stall with out_valid = 0 still freezes; no bubble filling.

Test Plan:
- Reset release, stall = 0, imem_rdata = 0xA0+pc:
  - out_pc sequence 0, 4, …, 0x1C; out_instr matches.
  - halted = 1 the edge 0x1C is issued; fetch_count = 8; pc stays 0x1C.
- Stall high for 3 cycles while out_pc = 0x8:
  - out_pc, out_instr and pc unchanged.
  - On release out_pc = 0xC next edge; fetch_count increments by 1 per unstalled cycle only.
- redirect_valid with redirect_pc = 0x4 while pc = 0x10, stall = 1:
  - next edge out_valid = 0, pc = 0x4; following edge out_pc = 0x4.
- redirect_pc = 0x13:
  - pc = 0x10; misalign_err high exactly one cycle.
- After halt, redirect_pc = 0x0:
  - HALT_STICKY = 0: halted clears, fetch resumes at 0x0.
  - HALT_STICKY = 1: halted stays 1, out_valid stays 0.
- Reset asserted mid-stream at pc = 0x14, out_valid = 1:
  - all outputs return to reset values immediately, without waiting for a clock edge.
- Wrap and saturation (parameter override):
  - RESET_PC = 0xFFFFFFFC, END_PC = 0x8: fetch order 0xFFFFFFFC, 0x0, 0x4, 0x8, then halt.
  - CNT_W = 2: fetch_count saturates at 3.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Instruction fetch stage: PC register, stall/backpressure, redirect with flush,
// end-of-program halt and a saturating fetch counter feeding a one-deep fetch/decode register.
module fetch_pc_unit #(
    parameter int               XLEN        = 32,
    parameter logic [XLEN-1:0]  RESET_PC    = '0,
    parameter logic [XLEN-1:0]  END_PC      = 'h1C,
    parameter bit               HALT_STICKY = 1'b0,
    parameter int               CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic [XLEN-1:0]  imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic             out_valid,
    output logic [XLEN-1:0]  out_pc,
    output logic [31:0]      out_instr,
    output logic             halted,
    output logic             misalign_err,
    output logic [CNT_W-1:0] fetch_count
);

    // Handshake: stall is decode's ready-low. While stall=1 the output register,
    // pc and fetch_count hold (even when out_valid=0); an instruction in the
    // output register is consumed on every edge where out_valid=1 and stall=0.

    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pc_n;
    logic             out_valid_n;
    logic [XLEN-1:0]  out_pc_n;
    logic [31:0]      out_instr_n;
    logic             halted_n;
    logic             misalign_n;
    logic [CNT_W-1:0] fetch_count_n;

    assign imem_addr = pc;

    // Priority per edge: redirect > halted > stall > advance.
    always_comb begin
        pc_n          = pc;
        out_valid_n   = out_valid;
        out_pc_n      = out_pc;
        out_instr_n   = out_instr;
        halted_n      = halted;
        misalign_n    = 1'b0;
        fetch_count_n = fetch_count;

        if (redirect_valid) begin
            // Wrong-path flush: the held instruction is dropped, its payload kept.
            pc_n        = {redirect_pc[XLEN-1:2], 2'b00};
            out_valid_n = 1'b0;
            misalign_n  = (redirect_pc[1:0] != 2'b00);
            if (!HALT_STICKY) begin
                halted_n = 1'b0;
            end
        end else if (halted) begin
            if (!stall) begin
                out_valid_n = 1'b0;
            end
        end else if (!stall) begin
            out_pc_n    = pc;
            out_instr_n = imem_rdata;
            out_valid_n = 1'b1;
            if (!(&fetch_count)) begin
                fetch_count_n = fetch_count + CNT_W'(1);
            end
            if (pc == END_PC) begin
                halted_n = 1'b1;
            end else begin
                pc_n = pc + XLEN'(4);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc           <= RESET_PC;
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_instr    <= '0;
            halted       <= 1'b0;
            misalign_err <= 1'b0;
            fetch_count  <= '0;
        end else begin
            pc           <= pc_n;
            out_valid    <= out_valid_n;
            out_pc       <= out_pc_n;
            out_instr    <= out_instr_n;
            halted       <= halted_n;
            misalign_err <= misalign_n;
            fetch_count  <= fetch_count_n;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: three parameterisations driven by one directed-then-random
// stimulus sequence, each checked every cycle against a behavioural model.
module tb_fetch_pc_unit;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic [31:0] addr_w [N];
    logic [31:0] rd_w   [N];
    logic [31:0] opc_w  [N];
    logic [31:0] oin_w  [N];
    logic        ov_w   [N];
    logic        hl_w   [N];
    logic        me_w   [N];
    logic [15:0] fc0;
    logic [15:0] fc1;
    logic [1:0]  fc2;

    int checks = 0;
    int errors = 0;

    // Instruction memory: word at address a is 0xA0 + a.
    assign rd_w[0] = 32'hA0 + addr_w[0];
    assign rd_w[1] = 32'hA0 + addr_w[1];
    assign rd_w[2] = 32'hA0 + addr_w[2];

    always #5 clk = ~clk;

    fetch_pc_unit dut0 (
        .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .imem_addr(addr_w[0]), .imem_rdata(rd_w[0]),
        .out_valid(ov_w[0]), .out_pc(opc_w[0]), .out_instr(oin_w[0]),
        .halted(hl_w[0]), .misalign_err(me_w[0]), .fetch_count(fc0)
    );

    fetch_pc_unit #(.HALT_STICKY(1'b1)) dut1 (
        .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .imem_addr(addr_w[1]), .imem_rdata(rd_w[1]),
        .out_valid(ov_w[1]), .out_pc(opc_w[1]), .out_instr(oin_w[1]),
        .halted(hl_w[1]), .misalign_err(me_w[1]), .fetch_count(fc1)
    );

    fetch_pc_unit #(.RESET_PC(32'hFFFF_FFFC), .END_PC(32'h8), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .imem_addr(addr_w[2]), .imem_rdata(rd_w[2]),
        .out_valid(ov_w[2]), .out_pc(opc_w[2]), .out_instr(oin_w[2]),
        .halted(hl_w[2]), .misalign_err(me_w[2]), .fetch_count(fc2)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] out_pc;
        logic [31:0] out_instr;
        bit          ov;
        bit          halted;
        bit          mis;
        int unsigned cnt;
    } mstate_t;

    logic [31:0] reset_pc_p [N] = '{32'h0, 32'h0, 32'hFFFF_FFFC};
    logic [31:0] end_pc_p   [N] = '{32'h1C, 32'h1C, 32'h8};
    bit          sticky_p   [N] = '{1'b0, 1'b1, 1'b0};
    int unsigned cmax_p     [N] = '{65535, 65535, 3};

    mstate_t m [N];

    function automatic mstate_t rst_state(int k);
        mstate_t s;
        s.pc = reset_pc_p[k];
        s.out_pc = 32'h0;
        s.out_instr = 32'h0;
        s.ov = 1'b0;
        s.halted = 1'b0;
        s.mis = 1'b0;
        s.cnt = 0;
        return s;
    endfunction

    function automatic mstate_t model_next(mstate_t s, int k, bit st, bit rv, logic [31:0] rpc);
        mstate_t n = s;
        n.mis = 1'b0;
        if (rv) begin
            n.pc = rpc - (rpc % 4);
            n.ov = 1'b0;
            n.mis = (rpc % 4) != 0;
            if (!sticky_p[k]) n.halted = 1'b0;
        end else if (s.halted) begin
            if (!st) n.ov = 1'b0;
        end else if (!st) begin
            n.out_pc = s.pc;
            n.out_instr = 32'hA0 + s.pc;
            n.ov = 1'b1;
            n.cnt = (s.cnt < cmax_p[k]) ? s.cnt + 1 : s.cnt;
            if (s.pc == end_pc_p[k]) n.halted = 1'b1;
            else n.pc = 32'((64'(s.pc) + 64'd4) % 64'h1_0000_0000);
        end
        return n;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] fc;
        for (int k = 0; k < N; k++) begin
            fc = (k == 0) ? {16'h0, fc0} : (k == 1) ? {16'h0, fc1} : {30'h0, fc2};
            chk($sformatf("d%0d.imem_addr", k), addr_w[k], m[k].pc);
            chk($sformatf("d%0d.out_valid", k), {31'h0, ov_w[k]}, {31'h0, m[k].ov});
            chk($sformatf("d%0d.out_pc", k), opc_w[k], m[k].out_pc);
            chk($sformatf("d%0d.out_instr", k), oin_w[k], m[k].out_instr);
            chk($sformatf("d%0d.halted", k), {31'h0, hl_w[k]}, {31'h0, m[k].halted});
            chk($sformatf("d%0d.misalign_err", k), {31'h0, me_w[k]}, {31'h0, m[k].mis});
            chk($sformatf("d%0d.fetch_count", k), fc, m[k].cnt);
        end
    endtask

    // ---------------- driver ----------------
    task automatic cycle();
        @(posedge clk);
        for (int k = 0; k < N; k++) begin
            m[k] = reset ? rst_state(k) : model_next(m[k], k, stall, redirect_valid, redirect_pc);
        end
        #1;
        check_all();
    endtask

    task automatic step(bit st, bit rv, logic [31:0] rpc);
        stall = st;
        redirect_valid = rv;
        redirect_pc = rpc;
        cycle();
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        int r;
        logic [31:0] rpc;
        reset = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        for (int k = 0; k < N; k++) m[k] = rst_state(k);
        #1;
        check_all();
        cycle();
        reset = 1'b0;

        // Straight-line run to END_PC and beyond: halt, pc frozen, saturation in dut2.
        run(11);

        // Redirect out of halt: dut0/dut2 resume at 0, dut1 stays halted.
        step(1'b0, 1'b1, 32'h0);
        run(3);                       // dut0 out_pc = 0x8 now
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);
        run(2);                       // out_pc 0xC, then 0x10 (pc = 0x14)

        // Redirect while stalled, then misaligned redirect.
        step(1'b1, 1'b1, 32'h4);
        run(2);
        step(1'b0, 1'b1, 32'h13);
        run(3);
        step(1'b1, 1'b1, 32'h1C);     // redirect straight to END_PC
        run(3);

        // Randomised stall/redirect traffic.
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 15);
            if (r < 2) begin
                rpc = ($urandom_range(0, 9) < 8) ? 32'($urandom_range(0, 40)) : 32'($urandom);
                step($urandom_range(0, 2) == 0, 1'b1, rpc);
            end else begin
                step($urandom_range(0, 2) == 0, 1'b0, 32'($urandom));
            end
        end

        // Asynchronous reset mid-stream with pc = 0x14 and out_valid = 1.
        step(1'b0, 1'b1, 32'h10);
        step(1'b0, 1'b0, 32'h0);
        #3;
        reset = 1'b1;
        #1;
        for (int k = 0; k < N; k++) m[k] = rst_state(k);
        check_all();
        step(1'b0, 1'b0, 32'h0);
        reset = 1'b0;
        run(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
